// File: rtl/bist_pkg.sv
// Shared constants and state encoding for the self-test report transmitter.
// BIST_REPORT_CHECKSUM_EN appends an XOR checksum byte to the frame.
package bist_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    NEXT  = 3'd4
  } state_t;

`ifdef BIST_REPORT_CHECKSUM_EN
  localparam int NBYTES = 11;
`else
  localparam int NBYTES = 10;
`endif

endpackage

// File: rtl/bist_report_tx_if.sv
// Self-test result bus: counters and done flag in, UART line and status out.
interface bist_report_tx_if #(
  parameter int CNT_W = 9
);
  logic             done;
  logic [CNT_W-1:0] t1attempts;
  logic [CNT_W-1:0] t1fails;
  logic [CNT_W-1:0] t2attempts;
  logic [CNT_W-1:0] t2fails;
  logic             txd;
  logic             busy;
  logic             pass;
  logic             pass_valid;
  logic             report_done;

  modport master (
    output done, t1attempts, t1fails, t2attempts, t2fails,
    input  txd, busy, pass, pass_valid, report_done
  );

  modport slave (
    input  done, t1attempts, t1fails, t2attempts, t2fails,
    output txd, busy, pass, pass_valid, report_done
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first; loads a byte on start while ready.
module uart_tx_byte
  import bist_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       byte_done,
  output logic       txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  assign ready     = (state == IDLE);
  assign byte_done = (state == STOP) && (cnt == LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (start) begin
            sh    <= data;
            cnt   <= '0;
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= sh[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              // txd takes the next bit straight from the unshifted register
              bit_idx <= bit_idx + 1'b1;
              sh      <= {1'b0, sh[7:1]};
              txd     <= sh[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bist_report_tx.sv
// Captures self-test counters on done rising, latches the verdict and sends
// the result frame over UART. BIST_REPORT_CHECKSUM_EN adds a checksum byte.
module bist_report_tx
  import bist_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 9,
  parameter int EXP_ATTEMPTS = 256
) (
  input  logic             clock,
  input  logic             reset_n,
  bist_report_tx_if.slave  bus
);

  localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(EXP_ATTEMPTS);
  localparam logic [3:0]       LAST_IDX = 4'(NBYTES);

  logic [1:0]  rst_sync;
  logic        rst_n;
  state_t      state;
  logic [3:0]  idx;
  logic        done_q;
  logic [15:0] s_t1a, s_t1f, s_t2a, s_t2f;
  logic        pass_r, pass_valid_r, busy_r, report_done_r;
  logic        trigger, verdict, start, ready, byte_done, txd;
  logic [7:0]  tx_byte;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign trigger = bus.done && !done_q && (state == IDLE) && ready;
  assign verdict = (bus.t1fails == '0) && (bus.t2fails == '0) &&
                   (bus.t1attempts == EXP_CNT) && (bus.t2attempts == EXP_CNT);

  // Header is constant, so byte 0 launches in the capture cycle itself.
  assign start = trigger || ((state == NEXT) && (idx != LAST_IDX) && ready);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      done_q        <= 1'b0;
      s_t1a         <= '0;
      s_t1f         <= '0;
      s_t2a         <= '0;
      s_t2f         <= '0;
      pass_r        <= 1'b0;
      pass_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      report_done_r <= 1'b0;
    end else begin
      done_q        <= bus.done;
      report_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            s_t1a        <= 16'(bus.t1attempts);
            s_t1f        <= 16'(bus.t1fails);
            s_t2a        <= 16'(bus.t2attempts);
            s_t2f        <= 16'(bus.t2fails);
            pass_r       <= verdict;
            pass_valid_r <= 1'b1;
            busy_r       <= 1'b1;
            idx          <= '0;
            state        <= DATA;
          end
        end
        DATA: begin
          if (byte_done) begin
            idx   <= idx + 1'b1;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            idx           <= '0;
            busy_r        <= 1'b0;
            report_done_r <= 1'b1;
            state         <= IDLE;
          end else if (ready) begin
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIST_REPORT_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = s_t1a[15:8] ^ s_t1a[7:0] ^ s_t1f[15:8] ^ s_t1f[7:0] ^
                    s_t2a[15:8] ^ s_t2a[7:0] ^ s_t2f[15:8] ^ s_t2f[7:0] ^
                    {7'b0, pass_r};
`endif

  always_comb begin
    tx_byte = '0;
    case (idx)
      4'd0: tx_byte = FRAME_HEADER;
      4'd1: tx_byte = s_t1a[15:8];
      4'd2: tx_byte = s_t1a[7:0];
      4'd3: tx_byte = s_t1f[15:8];
      4'd4: tx_byte = s_t1f[7:0];
      4'd5: tx_byte = s_t2a[15:8];
      4'd6: tx_byte = s_t2a[7:0];
      4'd7: tx_byte = s_t2f[15:8];
      4'd8: tx_byte = s_t2f[7:0];
      4'd9: tx_byte = {7'b0, pass_r};
`ifdef BIST_REPORT_CHECKSUM_EN
      4'd10: tx_byte = checksum;
`endif
      default: tx_byte = '0;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .data      (tx_byte),
    .ready     (ready),
    .byte_done (byte_done),
    .txd       (txd)
  );

  assign bus.txd         = txd;
  assign bus.busy        = busy_r;
  assign bus.pass        = pass_r;
  assign bus.pass_valid  = pass_valid_r;
  assign bus.report_done = report_done_r;

endmodule

// File: tb/tb_bist_report_tx.sv
// Scoreboard bench: stimulus pushes the expected frame bytes, a UART
// receiver process pops and compares each received byte.
module tb_bist_report_tx;

  localparam int CPB = 4;
`ifdef BIST_REPORT_CHECKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * (10 * CPB + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bist_report_tx_if #(.CNT_W(9)) bus ();

  bist_report_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W(9),
    .EXP_ATTEMPTS(256)
  ) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int pass_n = 0;
  int total_n = 0;
  logic [7:0] exp_q[$];
  int rd_count = 0;
  int frames_started = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Reference model: frame contents straight from the byte-layout rules.
  task automatic push_frame(input int a1, input int f1, input int a2,
                            input int f2, output int p);
    int vals[4];
    int bytes[$];
    int x;
    vals = '{a1, f1, a2, f2};
    p = (f1 == 0 && f2 == 0 && a1 == 256 && a2 == 256) ? 1 : 0;
    bytes.push_back(165);
    foreach (vals[i]) begin
      bytes.push_back(vals[i] / 256);
      bytes.push_back(vals[i] % 256);
    end
    bytes.push_back(p);
    x = 0;
    for (int i = 1; i <= 9; i++) x = x ^ bytes[i];
    if (NB == 11) bytes.push_back(x);
    foreach (bytes[i]) exp_q.push_back(8'(bytes[i]));
  endtask

  // UART receiver / scoreboard checker.
  bit rx_on = 1'b0;
  int rx_t = 0;
  logic [7:0] rx_b = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (bus.txd === 1'b0) begin
        rx_on = 1'b1;
        rx_t = 0;
      end
    end else begin
      rx_t++;
      if (rx_t >= CPB + 1 && rx_t <= 8 * CPB + 1 && (rx_t - 1) % CPB == 0)
        rx_b[3'((rx_t - 1) / CPB - 1)] = bus.txd;
      if (rx_t == 9 * CPB + 1) begin
        rx_on = 1'b0;
        chk("rx_stop_bit", int'(bus.txd), 1);
        if (exp_q.size() == 0) begin
          total_n++;
          $display("FAIL rx_unexpected_byte: got %0d, want no byte", rx_b);
        end else begin
          chk("rx_byte", int'(rx_b), int'(exp_q.pop_front()));
        end
      end
    end
  end

  int busy_run = 0;
  bit busy_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_run = 0;
      busy_prev = 1'b0;
    end else begin
      if (bus.busy && !busy_prev) frames_started++;
      if (bus.busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_cycles", busy_run, FRAME_CYC);
        busy_run = 0;
      end
      busy_prev = bus.busy;
    end
  end

  int rd_run = 0;
  always @(negedge clk) begin
    if (bus.report_done) begin
      if (rd_run == 0) rd_count++;
      rd_run++;
    end else if (rd_run != 0) begin
      chk("report_done_width", rd_run, 1);
      rd_run = 0;
    end
  end

  task automatic run_frame(input int a1, input int f1, input int a2,
                           input int f2, input bit glitch);
    int p, rd0, fs0;
    bit got;
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    push_frame(a1, f1, a2, f2, p);
    bus.t1attempts = 9'(a1);
    bus.t1fails    = 9'(f1);
    bus.t2attempts = 9'(a2);
    bus.t2fails    = 9'(f2);
    rd0 = rd_count;
    fs0 = frames_started;
    bus.done = 1'b1;
    @(negedge clk);
    chk("start_bit_latency", int'(bus.txd), 0);
    chk("busy_at_capture", int'(bus.busy), 1);
    chk("pass", int'(bus.pass), p);
    chk("pass_valid", int'(bus.pass_valid), 1);
    if (glitch) begin
      repeat (100) @(negedge clk);
      bus.done = 1'b0;
      bus.t1attempts = 9'($urandom_range(0, 511));
      bus.t1fails    = 9'($urandom_range(1, 511));
      bus.t2attempts = 9'($urandom_range(0, 511));
      bus.t2fails    = 9'($urandom_range(0, 511));
      repeat (2) @(negedge clk);
      bus.done = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 3 * FRAME_CYC && !got; i++) begin
      @(negedge clk);
      if (rd_count != rd0) got = 1'b1;
    end
    chk("frame_completed", int'(got), 1);
    repeat (2) @(negedge clk);
    chk("rx_queue_drained", exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
    chk("report_done_count", rd_count - rd0, 1);
    chk("pass_held", int'(bus.pass), p);
    repeat (50) @(negedge clk);
    chk("frames_started", frames_started - fs0, 1);
    chk("txd_idle_after", int'(bus.txd), 1);
    chk("busy_idle_after", int'(bus.busy), 0);
  endtask

  initial begin
    int p, fs0;
    bus.done = 1'b0;
    bus.t1attempts = '0;
    bus.t1fails = '0;
    bus.t2attempts = '0;
    bus.t2fails = '0;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(bus.txd), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_pass", int'(bus.pass), 0);
    chk("reset_pass_valid", int'(bus.pass_valid), 0);
    chk("reset_report_done", int'(bus.report_done), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_txd", int'(bus.txd), 1);

    run_frame(256, 0, 256, 0, 1'b0);
    run_frame(256, 3, 256, 0, 1'b0);
    run_frame(255, 0, 256, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_frame(256, 0, 256, 0, 1'b0);
      else
        run_frame(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 1'b0);
    end
    run_frame(256, 0, 256, 0, 1'b1);

    // Reset pulsed in the DATA phase of byte 2.
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    push_frame(256, 0, 256, 0, p);
    bus.t1attempts = 9'd256;
    bus.t1fails    = 9'd0;
    bus.t2attempts = 9'd256;
    bus.t2fails    = 9'd0;
    bus.done = 1'b1;
    repeat (2 * (10 * CPB + 1) + 15) @(negedge clk);
    bus.done = 1'b0;
    fs0 = frames_started;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_txd_high", int'(bus.txd), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_pass_valid", int'(bus.pass_valid), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort_no_restart", frames_started - fs0, 0);
    chk("abort_txd_idle", int'(bus.txd), 1);
    chk("abort_pass_valid_after", int'(bus.pass_valid), 0);

    run_frame(256, 0, 256, 1, 1'b0);
    run_frame(256, 0, 256, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
